// File: rtl/tx_waveform_player.sv
// tx_waveform_player
// Buffers a host-loaded waveform of parallel DAC sample vectors and plays it
// out one vector per clock, with finite or infinite repetition.
//
// Ports:
//   clock, reset      sole clock (rising edge), asynchronous active-high reset
//   wr_valid/wr_ready loader handshake; wr_data is one sample vector,
//   wr_data/wr_last   wr_last marks the final vector of the waveform
//   start, stop       single-cycle playback request / abort (stop wins)
//   repeat_count      passes to play, 0 = infinite, sampled at start
//   dac_data          playback vector, lane k at [16*(k+1)-1:16*k], 0 when idle
//   dac_valid         dac_data carries a waveform vector
//   busy              high while playing
//   done              one-cycle pulse on the final vector of a finite playback
//
// state | meaning
// IDLE  | accepting loader beats, waiting for start
// PLAY  | reading the buffer, one vector per clock
module tx_waveform_player #(
    parameter int NUMBER_OF_LINE = 8,
    parameter int DEPTH          = 256,
    parameter int ADDR_WIDTH     = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [16*NUMBER_OF_LINE-1:0] wr_data,
    input  logic                         wr_last,
    input  logic                         start,
    input  logic                         stop,
    input  logic [15:0]                  repeat_count,
    output logic [16*NUMBER_OF_LINE-1:0] dac_data,
    output logic                         dac_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int W = 16 * NUMBER_OF_LINE;

    typedef enum logic {IDLE, PLAY} state_t;

    state_t                state;
    logic [W-1:0]          mem [DEPTH];
    logic                  idle_q;
    logic                  loaded;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   length;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [15:0]           pass_cnt;
    logic [15:0]           count_q;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  wr_end;
    logic                  at_end;
    logic                  wrap;

    // idle_q is registered so wr_ready stays low until the first clock after reset.
    assign wr_ready = idle_q && !start;
    assign accept   = wr_valid && wr_ready;
    // A beat arriving after a completed load starts a fresh waveform at 0.
    assign waddr    = loaded ? '0 : wr_ptr;
    assign wr_end   = wr_last || (waddr == ADDR_WIDTH'(DEPTH - 1));
    assign at_end   = ({1'b0, rd_addr} == (length - (ADDR_WIDTH+1)'(1)));
    assign wrap     = (count_q == 16'd0) || (pass_cnt < (count_q - 16'd1));

    always_ff @(posedge clock) begin
        if (accept) begin
            mem[waddr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idle_q    <= 1'b0;
            loaded    <= 1'b0;
            wr_ptr    <= '0;
            length    <= '0;
            rd_addr   <= '0;
            pass_cnt  <= '0;
            count_q   <= '0;
            dac_data  <= '0;
            dac_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dac_valid <= 1'b0;
                    dac_data  <= '0;
                    done      <= 1'b0;
                    if (accept) begin
                        if (wr_end) begin
                            length <= {1'b0, waddr} + (ADDR_WIDTH+1)'(1);
                            loaded <= 1'b1;
                            wr_ptr <= '0;
                        end else begin
                            loaded <= 1'b0;
                            wr_ptr <= waddr + ADDR_WIDTH'(1);
                        end
                    end
                    if (start && !stop && loaded) begin
                        state    <= PLAY;
                        busy     <= 1'b1;
                        idle_q   <= 1'b0;
                        count_q  <= repeat_count;
                        rd_addr  <= '0;
                        pass_cnt <= '0;
                    end else begin
                        idle_q <= 1'b1;
                    end
                end
                PLAY: begin
                    done <= 1'b0;
                    if (stop) begin
                        // The read issued this cycle is dropped.
                        state     <= IDLE;
                        busy      <= 1'b0;
                        idle_q    <= 1'b1;
                        dac_valid <= 1'b0;
                        dac_data  <= '0;
                    end else begin
                        dac_valid <= 1'b1;
                        dac_data  <= mem[rd_addr];
                        if (at_end) begin
                            if (wrap) begin
                                rd_addr  <= '0;
                                pass_cnt <= pass_cnt + 16'd1;
                            end else begin
                                // Final read: its vector appears next cycle, already idle.
                                state  <= IDLE;
                                busy   <= 1'b0;
                                idle_q <= 1'b1;
                                done   <= 1'b1;
                            end
                        end else begin
                            rd_addr <= rd_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_waveform_player.sv
module tb_tx_waveform_player;

    logic         clock = 1'b0;
    logic         reset;
    logic         wr_valid;
    logic         wr_ready;
    logic [127:0] wr_data;
    logic         wr_last;
    logic         start;
    logic         stop;
    logic [15:0]  repeat_count;
    logic [127:0] dac_data;
    logic         dac_valid;
    logic         busy;
    logic         done;

    tx_waveform_player #(.NUMBER_OF_LINE(8), .DEPTH(256), .ADDR_WIDTH(8)) dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
        .start(start), .stop(stop), .repeat_count(repeat_count),
        .dac_data(dac_data), .dac_valid(dac_valid), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [127:0] data;
        logic         done;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] wave [256];
    int           wave_len = 0;
    int           total = 0;
    int           bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lane k of vector n is 16'h0n0k (kind 0), shifted index for other kinds,
    // kind 1 is a ramp on lane 0.
    function automatic logic [127:0] gen(input int kind, input int idx);
        logic [127:0] v;
        for (int k = 0; k < 8; k++) begin
            if (kind == 1) v[16*k +: 16] = (k == 0) ? 16'(idx) : 16'(idx * 3 + k * 4096);
            else           v[16*k +: 16] = 16'(((idx + kind) << 8) | k);
        end
        return v;
    endfunction

    // Advance one clock and sample at the falling edge; valid output is
    // popped from the scoreboard, idle output must be all zero.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (dac_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {127'b0, dac_valid}, 128'd0);
            end else begin
                e = sb.pop_front();
                chk("dac_data", dac_data, e.data);
                chk("done", {127'b0, done}, {127'b0, e.done});
            end
        end else begin
            chk("idle_data", dac_data, 128'd0);
            chk("idle_done", {127'b0, done}, 128'd0);
        end
    endtask

    task automatic load(input int first, input int n, input bit last, input int kind);
        for (int i = 0; i < n; i++) begin
            wave[first + i] = gen(kind, first + i);
            chk("wr_ready_load", {127'b0, wr_ready}, 128'd1);
            wr_valid = 1'b1;
            wr_data  = wave[first + i];
            wr_last  = last && (i == n - 1);
            tick();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        wr_data  = '0;
        wave_len = first + n;
    endtask

    // Pushes the expected stream, pulses start, returns having observed T+1.
    task automatic play(input int count, input int n);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            e.data = wave[j % wave_len];
            e.done = (count != 0) && (j == n - 1);
            sb.push_back(e);
        end
        repeat_count = 16'(count);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat_count = 16'($urandom_range(0, 65535));
        chk("busy_after_start", {127'b0, busy}, 128'd1);
        chk("wr_ready_in_play", {127'b0, wr_ready}, 128'd0);
        chk("valid_T1", {127'b0, dac_valid}, 128'd0);
    endtask

    task automatic run_valid(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("dac_valid", {127'b0, dac_valid}, 128'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
        start = 1'b0; stop = 1'b0; repeat_count = '0;
        #1;
        chk("rst_valid", {127'b0, dac_valid}, 128'd0);
        chk("rst_data", dac_data, 128'd0);
        chk("rst_busy", {127'b0, busy}, 128'd0);
        chk("rst_wr_ready", {127'b0, wr_ready}, 128'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("wr_ready_after_rst", {127'b0, wr_ready}, 128'd1);

        // start with nothing loaded
        repeat_count = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("noload_busy", {127'b0, busy}, 128'd0);
        tick(); tick();
        chk("noload_busy2", {127'b0, busy}, 128'd0);

        // W0..W3, two passes
        load(0, 4, 1'b1, 0);
        play(2, 8);
        run_valid(8);
        chk("busy_last", {127'b0, busy}, 128'd0);
        chk("wr_ready_last", {127'b0, wr_ready}, 128'd1);
        tick();
        chk("valid_after", {127'b0, dac_valid}, 128'd0);

        // infinite, stop after 13 vectors, then replay
        play(0, 13);
        run_valid(13);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_valid", {127'b0, dac_valid}, 128'd0);
        chk("stop_busy", {127'b0, busy}, 128'd0);
        tick(); tick();
        play(1, 4);
        run_valid(4);
        tick();

        // start together with a loader beat: beat rejected, playback starts
        wr_valid = 1'b1; wr_data = {8{16'hBEEF}}; wr_last = 1'b1;
        start = 1'b1;
        #1;
        chk("wr_ready_start", {127'b0, wr_ready}, 128'd0);
        start = 1'b0;
        play(1, 4);
        wr_valid = 1'b0; wr_last = 1'b0; wr_data = '0;
        run_valid(4);
        tick();

        // full-depth ramp without wr_last
        load(0, 256, 1'b0, 1);
        play(1, 256);
        run_valid(256);
        tick();
        load(0, 1, 1'b0, 16);
        repeat_count = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("partial_busy", {127'b0, busy}, 128'd0);
        load(1, 1, 1'b1, 16);
        play(1, 2);
        run_valid(2);
        tick();

        // length 1
        load(0, 1, 1'b1, 5);
        play(1, 1);
        run_valid(1);
        chk("len1_busy", {127'b0, busy}, 128'd0);
        tick();
        play(3, 3);
        run_valid(3);
        tick();

        // reset during infinite playback
        load(0, 4, 1'b1, 0);
        play(0, 5);
        run_valid(5);
        reset = 1'b1;
        #1;
        chk("arst_valid", {127'b0, dac_valid}, 128'd0);
        chk("arst_data", dac_data, 128'd0);
        chk("arst_busy", {127'b0, busy}, 128'd0);
        chk("arst_done", {127'b0, done}, 128'd0);
        sb.delete();
        tick();
        reset = 1'b0;
        tick();
        chk("wr_ready_after_arst", {127'b0, wr_ready}, 128'd1);
        repeat_count = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("arst_start_ignored", {127'b0, busy}, 128'd0);
        tick(); tick();

        chk("sb_drained", 128'(sb.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_waveform_player.md
Name: tx_waveform_player

Overview:
Transmit-side counterpart to the receive DSP chain. It buffers a host-loaded waveform of parallel DAC sample vectors and plays it out, one vector per clock, in the same 16-bit x NUMBER_OF_LINE packed format that the DAC data paths use. It supports finite or infinite repetition, start/stop control and a completion pulse. It sits between the control/loader logic and a DAC data port.

Parameters:
NUMBER_OF_LINE, 8, samples per clock (lanes); lane k occupies bits [16*(k+1)-1:16*k].
DEPTH, 256, buffer depth in sample vectors (power of 2).
ADDR_WIDTH, 8, log2(DEPTH).

Ports:
clock  input  1  sole clock; all logic is on the rising edge.
reset  input  1  asynchronous, active-high reset.
wr_valid  input  1  loader beat valid.
wr_ready  output  1  beat accepted when wr_valid && wr_ready.
wr_data  input  16*NUMBER_OF_LINE  one sample vector.
wr_last  input  1  marks the final vector of the waveform.
start  input  1  single-cycle playback request.
stop  input  1  single-cycle abort request.
repeat_count  input  16  number of passes; 0 = infinite; sampled at start.
dac_data  output  16*NUMBER_OF_LINE  playback vector, two's complement.
dac_valid  output  1  dac_data carries a waveform vector.
busy  output  1  high while not IDLE.
done  output  1  one-cycle pulse on the final vector of a finite playback.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; loaded=0, wr_ptr=0, length=0, pass_cnt=0. wr_ready rises on the first clock after reset deasserts. RAM contents are undefined.
- Simple dual-port RAM, DEPTH x 16*NUMBER_OF_LINE, 1-cycle registered read.
- States: IDLE, PLAY.
- wr_ready = (state==IDLE) && !start. Writes are never accepted in PLAY or in a start cycle.
- Loading, on an accepted beat:
  - Write wr_data at wr_ptr.
  - If loaded=1 on this beat, it begins a new load: write to address 0 and clear loaded.
  - If wr_last=1 or wr_ptr==DEPTH-1: length<=wr_ptr+1 (ADDR_WIDTH+1 bits), loaded<=1, wr_ptr<=0.
  - Otherwise wr_ptr++.
- IDLE->PLAY transition:
  - Requires start=1, stop=0 and loaded=1 (this includes a load completed in an earlier cycle).
  - Latch repeat_count; rd_addr<=0; pass_cnt<=0.
  - start is ignored if loaded=0. stop has priority over start.
- PLAY:
  - rd_addr advances by 1 every cycle.
  - At rd_addr==length-1: if latched count==0 or pass_cnt<count-1, then rd_addr<=0 and pass_cnt++. The wrap is seamless, with no gap vector.
  - Otherwise this is the final read; state<=IDLE next cycle.
- Latency: start accepted in cycle T gives dac_valid=1 with vector 0 in cycle T+2. Output is continuous thereafter.
  - Total valid cycles = length*count.
  - done=1 coincident with the last valid vector.
  - busy falls in the cycle that final vector appears; wr_ready rises in the same cycle.
- stop in PLAY at cycle S:
  - State becomes IDLE at S+1; the in-flight read is discarded.
  - dac_valid=0 and dac_data=0 from S+1 onward. No done pulse.
  - loaded stays 1, so the waveform can be replayed with start.
- dac_data is forced to 0 whenever dac_valid=0. Both are registered outputs.
- length=1 edge case: the same vector is output every cycle. With count=1, a single valid cycle with done=1.
- Reset mid-PLAY: outputs 0 immediately; loaded=0. A start after reset is ignored until a new load completes.
- repeat_count and wr_* changes during PLAY have no effect on the playback in progress.

Test Plan:
- Load W0..W3 (lane k of Wn = 16'h0n0k, wr_last on W3), repeat_count=2, start at T -> dac_valid high T+2..T+9, sequence W0 W1 W2 W3 W0 W1 W2 W3, done only at T+9, busy low from T+9, wr_ready high at T+9.
- Same load, repeat_count=0, start, stop after 13 valid vectors -> sequence wraps W3->W0 with no gap, dac_valid=0 and dac_data=0 the cycle after stop, done never pulses; a second start replays from W0.
- start with nothing loaded -> busy stays 0, dac_valid 0; start asserted together with wr_valid -> wr_ready=0, beat not written, playback starts.
- Load 256 beats with wr_last never asserted -> length=256; repeat_count=1 plays 256 vectors with a ramp on lane 0 (0..255) and done on vector 255. A following beat clears loaded, so start is ignored until the new load's wr_last.
- Assert reset at the 5th valid vector of an infinite playback -> dac_valid, dac_data, busy and done are 0 asynchronously; after release wr_ready=1 and start is ignored.
- length=1 load (single beat with wr_last), repeat_count=1 -> exactly one valid cycle, with done=1 in that cycle.
